// File: rtl/jk_excitation_sequencer.sv
// Sequencer that drives a bank of JK flip-flops toward queued target values.
// Each target gets a one-cycle J/K pulse, a programmable dwell, then a Q-feedback verify.
module jk_excitation_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_target,
  input  logic [DWELL_W-1:0]       in_dwell,
  input  logic [WIDTH-1:0]         q_fb,
  output logic [WIDTH-1:0]         J,
  output logic [WIDTH-1:0]         K,
  output logic                     busy,
  output logic                     done,
  output logic                     retry_seen,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  // Set only bits that must rise; J and K are mutually exclusive by construction.
  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] tgt,
                                                input logic [WIDTH-1:0] q);
    excite_j = tgt & ~q;
  endfunction

  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] tgt,
                                                input logic [WIDTH-1:0] q);
    excite_k = ~tgt & q;
  endfunction

  logic [WIDTH-1:0]   tgt_mem_q   [DEPTH];
  logic [DWELL_W-1:0] dwell_mem_q [DEPTH];

  state_t             state_q,  state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [WIDTH-1:0]   tgt_q,    tgt_d;
  logic [DWELL_W-1:0] dwell_q,  dwell_d;
  logic [DWELL_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   j_q,      j_d;
  logic [WIDTH-1:0]   k_q,      k_d;
  logic               done_q,   done_d;
  logic               retry_q,  retry_d;
  logic               push;
  logic               pop;

  // Acceptance depends on occupancy only, never on a same-edge pop.
  assign in_ready = !RESET && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    retry_d  = retry_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          tgt_d   = tgt_mem_q[rd_ptr_q];
          dwell_d = dwell_mem_q[rd_ptr_q];
          j_d     = excite_j(tgt_mem_q[rd_ptr_q], q_fb);
          k_d     = excite_k(tgt_mem_q[rd_ptr_q], q_fb);
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = dwell_q;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          retry_d = 1'b1;
          j_d     = excite_j(tgt_q, q_fb);
          k_d     = excite_k(tgt_q, q_fb);
          state_d = S_DRIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // Storage is data-only; occupancy tracking makes stale slots unobservable.
  always_ff @(posedge CLK) begin
    if (push) begin
      tgt_mem_q[wr_ptr_q]   <= in_target;
      dwell_mem_q[wr_ptr_q] <= in_dwell;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tgt_q    <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      retry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tgt_q    <= tgt_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      retry_q  <= retry_d;
    end
  end

  assign J          = j_q;
  assign K          = k_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign retry_seen = retry_q;
  assign count      = count_q;

endmodule
